// File: rtl/rs232_response_serializer.sv
// Serializes a captured response frame to a byte UART, top lane first, using a
// start-pulse / busy handshake per byte; flags overruns and illegal lengths.
module rs232_response_serializer #(
    parameter int unsigned MAX_BYTES = 11,
    parameter int unsigned TOP_LANE  = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MAX_BYTES*8-1:0] tx_bytes,
    input  logic [3:0]             tx_num_bytes,
    input  logic                   tx_valid,
    input  logic                   uart_tx_busy,
    output logic [7:0]             uart_tx_byte,
    output logic                   uart_tx_start,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun,
    output logic                   length_error
);

    localparam int unsigned ShiftW = (TOP_LANE + 1) * 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitAck,
        StWaitIdle
    } state_e;

    state_e              state_q, state_d;
    logic [ShiftW-1:0]   shift_q, shift_d;
    logic [3:0]          remaining_q, remaining_d;
    logic                tx_valid_last_q;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                overrun_q, overrun_d;
    logic                length_error_q, length_error_d;

    logic                request;
    logic                len_ok;

    // Lanes above TOP_LANE are never transmitted.
    logic                unused_high_lanes;
    assign unused_high_lanes = ^tx_bytes[MAX_BYTES*8-1:ShiftW];

    assign request = tx_valid & ~tx_valid_last_q;
    assign len_ok  = (tx_num_bytes != 4'd0) && ({28'd0, tx_num_bytes} <= (TOP_LANE + 1));

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        remaining_d    = remaining_q;
        tx_byte_d      = tx_byte_q;
        start_d        = 1'b0;
        busy_d         = busy_q;
        frame_done_d   = 1'b0;
        overrun_d      = overrun_q;
        length_error_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (request) begin
                    if (len_ok) begin
                        shift_d     = tx_bytes[ShiftW-1:0];
                        remaining_d = tx_num_bytes;
                        busy_d      = 1'b1;
                        state_d     = StStart;
                    end else begin
                        length_error_d = 1'b1;
                    end
                end
            end
            StStart: begin
                if (!uart_tx_busy) begin
                    tx_byte_d = shift_q[ShiftW-1 -: 8];
                    start_d   = 1'b1;
                    state_d   = StWaitAck;
                end
            end
            StWaitAck: begin
                if (uart_tx_busy) begin
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (!uart_tx_busy) begin
                    if (remaining_q != 4'd0) begin
                        remaining_d = remaining_q - 4'd1;
                    end
                    shift_d = shift_q << 8;
                    // A zero count cannot occur here, but must never strand the FSM.
                    if (remaining_q <= 4'd1) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (request && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            shift_q         <= '0;
            remaining_q     <= 4'd0;
            tx_valid_last_q <= 1'b0;
            tx_byte_q       <= 8'd0;
            start_q         <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            overrun_q       <= 1'b0;
            length_error_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            remaining_q     <= remaining_d;
            tx_valid_last_q <= tx_valid;
            tx_byte_q       <= tx_byte_d;
            start_q         <= start_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            overrun_q       <= overrun_d;
            length_error_q  <= length_error_d;
        end
    end

    assign uart_tx_byte  = tx_byte_q;
    assign uart_tx_start = start_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign overrun       = overrun_q;
    assign length_error  = length_error_q;

endmodule
